// File: rtl/amber48_uart_rx.sv
// amber48 8N1 UART receiver: mid-bit sampling, valid/ready byte output,
// sticky frame-error and overrun flags.
`timescale 1ns / 1ps

module amber48_uart_rx #(
    parameter int CLOCK_FREQ_HZ = 27_000_000,
    parameter int BAUD_RATE     = 115_200
) (
    input  logic       sys_clk,
    input  logic       rst_sync_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       err_clr_i,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          sync1;
    logic          rx_s;
    logic          rx_prev;
    logic [1:0]    fill;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_zero;
    logic          fall;
    logic          load_half;
    logic          load_full;
    logic          shift_en;
    logic          byte_done;
    logic          frame_set;

    assign cnt_zero = (cnt == '0);
    // fill gates edge detection until the pipeline holds real pin samples
    assign fall = (fill == 2'd3) && rx_prev && !rx_s;

    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            fill    <= 2'd0;
        end else begin
            sync1   <= rx_i;
            rx_s    <= sync1;
            rx_prev <= rx_s;
            if (fill != 2'd3) fill <= fill + 2'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state  <= IDLE;
            busy_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (cnt_zero) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (cnt_zero && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (cnt_zero) state_nxt = rx_s ? IDLE : BRK;
            BRK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        frame_set = 1'b0;
        unique case (state)
            IDLE:  load_half = fall;
            START: load_full = cnt_zero && !rx_s;
            DATA: begin
                shift_en  = cnt_zero;
                load_full = cnt_zero;
            end
            STOP: begin
                byte_done = cnt_zero && rx_s;
                frame_set = cnt_zero && !rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            if (load_half) cnt <= HALF_LD;
            else if (load_full) cnt <= FULL_LD;
            else if (!cnt_zero) cnt <= cnt - 1'b1;
            if (state != DATA) bit_idx <= 3'd0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

    // a set event in the same cycle as err_clr_i takes priority
    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            data_o      <= 8'd0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (byte_done && (!valid_o || ready_i)) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (byte_done && valid_o && !ready_i) overrun_o <= 1'b1;
            else if (err_clr_i) overrun_o <= 1'b0;
            if (frame_set) frame_err_o <= 1'b1;
            else if (err_clr_i) frame_err_o <= 1'b0;
        end
    end

endmodule
